// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns field-level instruction descriptors into 32-bit MIPS machine words.
//   Encoded words are queued in a small FIFO and emitted together with
//   sequential instruction-memory byte addresses. The self-test program loader
//   uses this block to fill instruction memory.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   clear           synchronous flush: empties FIFO, reloads address, clears err
//   in_valid/ready  descriptor handshake; in_ready is simply not-full
//   in_kind         0 ADD 1 SUB 2 AND 3 OR 4 NOR 5 SLT 6 JR 7 ADDI 8 SLTI
//                   9 LW 10 SW 11 BEQ 12 JAL 13 J (14, 15 illegal)
//   in_rs/rt/rd     register fields
//   in_imm          raw 16-bit immediate
//   in_addr         26-bit jump target
//   out_valid/ready word handshake; out_valid is simply not-empty
//   out_word        encoded word at the FIFO head
//   out_addr        byte address of out_word
//   err             sticky flag: an illegal kind was accepted
//   word_count      words popped since reset or clear (wraps at 16 bits)
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int          DWIDTH    = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_word,
    output logic [31:0]       out_addr,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;  // extra bit tells full from empty
    localparam logic [PW-1:0] PTR_ONE = 1;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_NOR  = 4'd4;
    localparam logic [3:0] K_SLT  = 4'd5;
    localparam logic [3:0] K_JR   = 4'd6;
    localparam logic [3:0] K_ADDI = 4'd7;
    localparam logic [3:0] K_SLTI = 4'd8;
    localparam logic [3:0] K_LW   = 4'd9;
    localparam logic [3:0] K_SW   = 4'd10;
    localparam logic [3:0] K_BEQ  = 4'd11;
    localparam logic [3:0] K_JAL  = 4'd12;
    localparam logic [3:0] K_J    = 4'd13;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DWIDTH-1:0] enc_word;
    logic              enc_legal;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_kind)
            K_ADD:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
            K_SUB:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
            K_AND:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24};
            K_OR:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h25};
            K_NOR:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h27};
            K_SLT:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
            K_JR:   enc_word = {6'h00, in_rs, 15'h0000, 6'h08};
            K_ADDI: enc_word = {6'h08, in_rs, in_rt, in_imm};
            K_SLTI: enc_word = {6'h0A, in_rs, in_rt, in_imm};
            K_LW:   enc_word = {6'h23, in_rs, in_rt, in_imm};
            K_SW:   enc_word = {6'h2B, in_rs, in_rt, in_imm};
            K_BEQ:  enc_word = {6'h04, in_rs, in_rt, in_imm};
            K_JAL:  enc_word = {6'h03, in_addr};
            K_J:    enc_word = {6'h02, in_addr};
            default: enc_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO status and handshakes
    // ------------------------------------------------------------------
    // Full depends only on registered pointers, so in_ready never sees
    // out_ready combinationally.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // Illegal kinds complete the handshake but never reach the FIFO.
    assign accept = in_valid & in_ready & ~clear;
    assign push   = accept & enc_legal;
    // Pop needs a non-empty FIFO, so an empty FIFO never falls through.
    assign pop    = out_valid & out_ready & ~clear;

    assign out_word = mem[rd_ptr[AW-1:0]];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            // NOTE: the storage is reset because out_word must read zero
            // after reset; a clear only moves the pointers.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= enc_word;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (accept && !enc_legal) begin
                err <= 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                out_addr   <= out_addr + 32'd4;
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed, table-driven bench for instr_encoder. Each table entry holds a
//   descriptor and its hand-encoded machine word; multi-cycle corners (burst,
//   full/backpressure, illegal kind, clear, async reset) are written out.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err;
    logic [15:0] word_count;

    instr_encoder #(
        .DWIDTH    (32),
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_addr   (out_addr),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] addr;
        logic [31:0] word;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr;
    logic [15:0] exp_cnt;
    logic [31:0] q [$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_kind  = v.kind;
        in_rs    = v.rs;
        in_rt    = v.rt;
        in_rd    = v.rd;
        in_imm   = v.imm;
        in_addr  = v.addr;
    endtask

    // Pop one word with out_ready held for a single edge and check it.
    task automatic pop_check(input string name, input logic [31:0] word);
        check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_word"}, out_word, word);
        check({name, "_addr"}, out_addr, exp_addr);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_addr += 32'd4;
        exp_cnt  += 16'd1;
    endtask

    initial begin
        vec_t        v;
        vec_t        fifth;
        logic [31:0] head;
        logic        take;

        //            kind  rs     rt     rd     imm        addr          word
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h0022_1820}; // ADD
        vecs[1]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       32'h0085_3022}; // SUB
        vecs[2]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'h0000, 26'h0,       32'h00E8_4824}; // AND
        vecs[3]  = '{4'd3,  5'd0,  5'd0,  5'd31, 16'h0000, 26'h0,       32'h0000_F825}; // OR
        vecs[4]  = '{4'd4,  5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FF_F827}; // NOR
        vecs[5]  = '{4'd5,  5'd2,  5'd3,  5'd1,  16'h0000, 26'h0,       32'h0043_082A}; // SLT
        vecs[6]  = '{4'd6,  5'd31, 5'd7,  5'd7,  16'h0000, 26'h0,       32'h03E0_0008}; // JR
        vecs[7]  = '{4'd7,  5'd0,  5'd8,  5'd0,  16'h0005, 26'h0,       32'h2008_0005}; // ADDI
        vecs[8]  = '{4'd8,  5'd3,  5'd4,  5'd0,  16'h8000, 26'h0,       32'h2864_8000}; // SLTI
        vecs[9]  = '{4'd9,  5'd8,  5'd9,  5'd0,  16'hFFFC, 26'h0,       32'h8D09_FFFC}; // LW
        vecs[10] = '{4'd10, 5'd29, 5'd31, 5'd0,  16'h0004, 26'h0,       32'hAFBF_0004}; // SW
        vecs[11] = '{4'd11, 5'd1,  5'd2,  5'd0,  16'h0003, 26'h0,       32'h1022_0003}; // BEQ
        vecs[12] = '{4'd12, 5'd5,  5'd6,  5'd7,  16'hFFFF, 26'h3FFFFFF, 32'h0FFF_FFFF}; // JAL
        vecs[13] = '{4'd13, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000100, 32'h0800_0100}; // J
        vecs[14] = '{4'd13, 5'd5,  5'd9,  5'd3,  16'hABCD, 26'h0000100, 32'h0800_0100}; // J, junk ignored

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_addr = '0;
        exp_addr = 32'h0; exp_cnt = 16'h0;
        #12;

        // ---- reset state
        check("rst_in_ready",   {31'b0, in_ready},  32'd1);
        check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
        check("rst_out_word",   out_word,           32'h0);
        check("rst_out_addr",   out_addr,           32'h0);
        check("rst_err",        {31'b0, err},       32'd0);
        check("rst_word_count", {16'b0, word_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---- basic encode with out_ready already high: no fall-through
        out_ready = 1'b1;
        drive(vecs[0]);
        step();
        in_valid = 1'b0;
        check("basic_valid", {31'b0, out_valid}, 32'd1);
        check("basic_word",  out_word,           32'h0022_1820);
        check("basic_addr",  out_addr,           32'h0);
        check("basic_cnt_before_pop", {16'b0, word_count}, 32'd0);
        step();
        out_ready = 1'b0;
        exp_addr = 32'd4; exp_cnt = 16'd1;
        check("basic_cnt",   {16'b0, word_count}, 32'd1);
        check("basic_empty", {31'b0, out_valid},  32'd0);

        // ---- table: every kind, one at a time
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            step();
            in_valid = 1'b0;
            pop_check($sformatf("vec%0d", i), vecs[i].word);
        end
        check("table_cnt",  {16'b0, word_count}, {16'b0, exp_cnt});
        check("table_addr", out_addr,            exp_addr);

        // ---- four-word burst, queued then drained
        drive(vecs[7]);  step();
        drive(vecs[9]);  step();
        drive(vecs[11]); step();
        drive(vecs[13]); step();
        in_valid = 1'b0;
        pop_check("burst0", 32'h2008_0005);
        pop_check("burst1", 32'h8D09_FFFC);
        pop_check("burst2", 32'h1022_0003);
        pop_check("burst3", 32'h0800_0100);
        check("burst_empty", {31'b0, out_valid}, 32'd0);

        // ---- full and backpressure
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill%0d_ready", i), {31'b0, in_ready}, 32'd1);
            drive(vecs[i + 1]);
            q.push_back(vecs[i + 1].word);
            step();
        end
        fifth = vecs[5];
        drive(fifth);
        check("full_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        step();
        check("full_hold_ready", {31'b0, in_ready}, 32'd0);
        check("full_hold_head",  out_word,           q[0]);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (q.size() != 0 || in_valid); c++) begin
            if (c == 0) check("full_ready_during_pop", {31'b0, in_ready}, 32'd0);
            if (out_valid) begin
                head = q.pop_front();
                check($sformatf("drain%0d_word", c), out_word, head);
                check($sformatf("drain%0d_addr", c), out_addr, exp_addr);
                exp_addr += 32'd4;
                exp_cnt  += 16'd1;
            end
            take = in_valid & in_ready;
            if (take) q.push_back(fifth.word);
            step();
            if (take) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("drain_leftover", q.size(), 32'd0);
        check("drain_cnt",  {16'b0, word_count}, {16'b0, exp_cnt});
        check("drain_empty", {31'b0, out_valid}, 32'd0);

        // ---- illegal kind: handshake completes, nothing pushed, err sticky
        v = vecs[0];
        v.kind = 4'd15;
        drive(v);
        check("illegal_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("illegal_err",   {31'b0, err},       32'd1);
        check("illegal_empty", {31'b0, out_valid}, 32'd0);
        v.kind = 4'd14;
        drive(v);
        step();
        in_valid = 1'b0;
        check("illegal14_empty", {31'b0, out_valid}, 32'd0);
        drive(vecs[1]);
        step();
        in_valid = 1'b0;
        pop_check("after_illegal", 32'h0085_3022);
        check("err_sticky", {31'b0, err}, 32'd1);

        // ---- clear mid-burst overrides push and pop
        drive(vecs[2]); step();
        drive(vecs[3]); step();
        drive(vecs[4]);
        out_ready = 1'b1;
        clear     = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_addr = 32'h0; exp_cnt = 16'h0;
        check("clr_empty", {31'b0, out_valid},  32'd0);
        check("clr_ready", {31'b0, in_ready},   32'd1);
        check("clr_addr",  out_addr,            32'h0);
        check("clr_cnt",   {16'b0, word_count}, 32'd0);
        check("clr_err",   {31'b0, err},        32'd0);
        drive(vecs[6]);
        step();
        in_valid = 1'b0;
        pop_check("after_clr", 32'h03E0_0008);
        check("after_clr_cnt", {16'b0, word_count}, 32'd1);

        // ---- asynchronous reset mid-burst, between clock edges
        drive(vecs[8]);  step();
        drive(vecs[10]); step();
        v = vecs[0];
        v.kind = 4'd14;
        drive(v);
        step();
        in_valid = 1'b0;
        check("prerst_err", {31'b0, err}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_addr = 32'h0; exp_cnt = 16'h0;
        check("arst_empty", {31'b0, out_valid},  32'd0);
        check("arst_ready", {31'b0, in_ready},   32'd1);
        check("arst_word",  out_word,            32'h0);
        check("arst_addr",  out_addr,            32'h0);
        check("arst_cnt",   {16'b0, word_count}, 32'd0);
        check("arst_err",   {31'b0, err},        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(vecs[12]);
        step();
        in_valid = 1'b0;
        pop_check("after_arst", 32'h0FFF_FFFF);
        check("after_arst_cnt", {16'b0, word_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder: accepts field-level instruction descriptors and emits 32-bit MIPS machine words.
- Supported subset: add, sub, and, or, nor, slt, jr, addi, slti, lw, sw, beq, jal, j.
- Encoded words are buffered in a small FIFO and emitted with sequential instruction-memory byte addresses.
- Used by the self-test program loader to fill instruction memory before the core leaves reset.

Parameters:
- DWIDTH, 32, instruction word width; fixed at 32.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- clear  input  1  synchronous flush; empties FIFO, reloads address to BASE_ADDR, clears err.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  FIFO can accept a descriptor; equals not-full.
- in_kind  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLT, 6 JR, 7 ADDI, 8 SLTI, 9 LW, 10 SW, 11 BEQ, 12 JAL, 13 J; 14 and 15 are illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate field, raw 16 bits.
- in_addr  input  26  jump target field.
- out_valid  output  1  word available; equals not-empty.
- out_ready  input  1  consumer accepts the word.
- out_word  output  32  encoded instruction at the FIFO head.
- out_addr  output  32  byte address of out_word.
- err  output  1  sticky; an illegal kind was presented.
- word_count  output  16  number of words popped since reset or clear; wraps at 16 bits.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_word=0, out_addr=BASE_ADDR, err=0, word_count=0, FIFO empty.
- Accept rule: a descriptor is accepted on a rising edge when in_valid=1, in_ready=1 and clear=0.
  - It is encoded combinationally and written into the FIFO on that same edge.
  - It becomes visible at out_* no earlier than the next cycle (1-cycle latency when the FIFO was empty).
- R-type encoding (kinds 0-5): {6'h00, rs, rt, rd, 5'h0, funct}.
  - funct: ADD 20, SUB 22, AND 24, OR 25, NOR 27, SLT 2A (hex).
- JR encoding: {6'h00, rs, 15'h0, 6'h08}. The rt and rd inputs are ignored.
- I-type encoding: {opcode, rs, rt, imm}.
  - opcode: ADDI 08, SLTI 0A, LW 23, SW 2B, BEQ 04 (hex).
  - imm is passed through unmodified; sign handling belongs to the decoder.
- J-type encoding: {opcode, addr}, with opcode J 02 and JAL 03. The rs, rt, rd and imm inputs are ignored.
- Illegal kinds (14, 15):
  - The handshake still completes; in_ready follows normal rules.
  - Nothing is pushed into the FIFO.
  - err is set and holds until reset or clear.
- Pop rule: a pop occurs when out_valid=1 and out_ready=1.
  - out_addr increments by 4 and wraps modulo 2^32.
  - word_count increments by 1.
- Simultaneous push and pop:
  - When the FIFO is non-empty, both take effect and occupancy is unchanged.
  - When the FIFO is empty, only the push takes effect; there is no fall-through.
- Full: in_ready=0 while occupancy equals DEPTH, even if a pop happens in the same cycle. No combinational path from out_ready to in_ready.
- Empty: out_valid=0; out_word holds its last value, which is don't-care.
- FIFO pointers: log2(DEPTH)+1 bits; wrap-around must preserve order.
- clear priority: clear overrides push and pop in the same cycle. Next cycle: empty, out_addr=BASE_ADDR, word_count=0, err=0.
- rst_n assertion mid-transfer: all state returns to reset values immediately, without waiting for a clock edge. In-flight words are lost.

Test Plan:
- Basic encode: ADD rs=1 rt=2 rd=3, out_ready=1 -> out_word=32'h00221820 at out_addr=0 one cycle after accept; word_count=1.
- Four-word burst: ADDI rt=8 rs=0 imm=5; LW rt=9 rs=8 imm=16'hFFFC; BEQ rs=1 rt=2 imm=3; J addr=26'h100.
  -> outputs 20080005, 8D09FFFC, 10220003, 08000100 at addresses 0, 4, 8, C.
- Full and backpressure: with DEPTH=4 and out_ready=0, push 5 descriptors.
  -> in_ready falls after the 4th; the 5th is held.
  -> with out_ready=1, words drain in order and the 5th is accepted.
- JR encode: JR rs=31 with rt=rd=7 -> out_word=03E00008.
- Illegal kind: kind=15 -> err=1; no word is emitted; later valid descriptors still encode correctly.
- Clear and reset: clear mid-burst -> empty, out_addr=0, err=0, word_count=0. rst_n pulse mid-burst -> identical state asynchronously.
